// File: rtl/mem_arbiter_if.sv
// Bundle of client-side and memory-side request/response handshakes for mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
    parameter int unsigned p_num_clients = 2,
    parameter int unsigned p_opaq_bits   = 8
);
    logic [p_num_clients-1:0]                  cli_req_val;
    logic [p_num_clients-1:0]                  cli_req_rdy;
    logic [p_num_clients-1:0]                  cli_req_op;
    logic [p_num_clients-1:0][31:0]            cli_req_addr;
    logic [p_num_clients-1:0][31:0]            cli_req_data;
    logic [p_num_clients-1:0][p_opaq_bits-1:0] cli_req_opaq;

    logic [p_num_clients-1:0]                  cli_resp_val;
    logic [p_num_clients-1:0]                  cli_resp_rdy;
    logic                                      cli_resp_op;
    logic [31:0]                               cli_resp_data;
    logic [p_opaq_bits-1:0]                    cli_resp_opaq;

    logic                                      mem_req_val;
    logic                                      mem_req_rdy;
    logic                                      mem_req_op;
    logic [31:0]                               mem_req_addr;
    logic [31:0]                               mem_req_data;
    logic [p_opaq_bits-1:0]                    mem_req_opaq;

    logic                                      mem_resp_val;
    logic                                      mem_resp_rdy;
    logic                                      mem_resp_op;
    logic [31:0]                               mem_resp_data;
    logic [p_opaq_bits-1:0]                    mem_resp_opaq;

    modport slave (
        input  cli_req_val, cli_req_op, cli_req_addr, cli_req_data, cli_req_opaq,
        input  cli_resp_rdy,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_op, mem_resp_data, mem_resp_opaq,
        output cli_req_rdy,
        output cli_resp_val, cli_resp_op, cli_resp_data, cli_resp_opaq,
        output mem_req_val, mem_req_op, mem_req_addr, mem_req_data, mem_req_opaq,
        output mem_resp_rdy
    );

    modport master (
        output cli_req_val, cli_req_op, cli_req_addr, cli_req_data, cli_req_opaq,
        output cli_resp_rdy,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_op, mem_resp_data, mem_resp_opaq,
        input  cli_req_rdy,
        input  cli_resp_val, cli_resp_op, cli_resp_data, cli_resp_opaq,
        input  mem_req_val, mem_req_op, mem_req_addr, mem_req_data, mem_req_opaq,
        input  mem_resp_rdy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among N clients; an ID FIFO
// remembers which client issued each outstanding request so responses route back.
module mem_arbiter #(
    parameter int unsigned p_num_clients  = 2,
    parameter int unsigned p_opaq_bits    = 8,
    parameter int unsigned p_max_inflight = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned c_ptr_w = (p_num_clients > 1) ? $clog2(p_num_clients) : 1;
    localparam int unsigned c_idx_w = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam int unsigned c_cnt_w = $clog2(p_max_inflight + 1);

    logic [c_ptr_w-1:0] ptr;
    logic [c_ptr_w-1:0] gnt;
    logic [c_ptr_w-1:0] head;
    logic               any_val;
    logic               full;
    logic               empty;
    logic               req_fire;
    logic               resp_fire;
    logic [c_idx_w-1:0] wptr;
    logic [c_idx_w-1:0] rptr;
    logic [c_cnt_w-1:0] count;
    logic [c_ptr_w-1:0] id_fifo [p_max_inflight];

    // First valid client at or after ptr, wrapping modulo N.
    always_comb begin
        logic [c_ptr_w-1:0] idx;
        any_val = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < p_num_clients; i++) begin
            idx = c_ptr_w'((32'(ptr) + i) % p_num_clients);
            if (!any_val && bus.cli_req_val[idx]) begin
                any_val = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign full      = (count == c_cnt_w'(p_max_inflight));
    assign empty     = (count == '0);
    assign head      = id_fifo[rptr];
    assign req_fire  = bus.mem_req_val & bus.mem_req_rdy;
    assign resp_fire = bus.mem_resp_val & bus.mem_resp_rdy;

    // Handshake outputs are qualified with rst so they read 0 throughout reset.
    always_comb begin
        bus.mem_req_val  = rst & any_val & ~full;
        bus.mem_req_op   = bus.cli_req_op[gnt];
        bus.mem_req_addr = bus.cli_req_addr[gnt];
        bus.mem_req_data = bus.cli_req_data[gnt];
        bus.mem_req_opaq = bus.cli_req_opaq[gnt];

        bus.cli_req_rdy  = '0;
        bus.cli_resp_val = '0;
        for (int unsigned i = 0; i < p_num_clients; i++) begin
            bus.cli_req_rdy[i]  = rst & any_val & ~full & bus.mem_req_rdy
                                  & (gnt == c_ptr_w'(i));
            bus.cli_resp_val[i] = rst & bus.mem_resp_val & ~empty
                                  & (head == c_ptr_w'(i));
        end

        bus.mem_resp_rdy  = rst & ~empty & bus.cli_resp_rdy[head];
        bus.cli_resp_op   = bus.mem_resp_op;
        bus.cli_resp_data = bus.mem_resp_data;
        bus.cli_resp_opaq = bus.mem_resp_opaq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (req_fire) begin
                ptr  <= (gnt == c_ptr_w'(p_num_clients - 1)) ? '0 : gnt + 1'b1;
                wptr <= (wptr == c_idx_w'(p_max_inflight - 1)) ? '0 : wptr + 1'b1;
            end
            if (resp_fire) begin
                rptr <= (rptr == c_idx_w'(p_max_inflight - 1)) ? '0 : rptr + 1'b1;
            end
            case ({req_fire, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            id_fifo[wptr] <= gnt;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: issued requests queue expected responses,
// a 1-cycle in-order memory model answers them, and responses are checked on delivery.
module tb_mem_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned OB = 8;
    localparam int unsigned MI = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.p_num_clients(N), .p_opaq_bits(OB)) bus ();

    mem_arbiter #(
        .p_num_clients (N),
        .p_opaq_bits   (OB),
        .p_max_inflight(MI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int unsigned   cli;
        logic          op;
        logic [31:0]   data;
        logic [OB-1:0] opaq;
    } exp_t;

    typedef struct {
        logic          op;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [OB-1:0] opaq;
    } mreq_t;

    exp_t        sb[$];
    mreq_t       memq[$];
    int unsigned grants[$];
    int unsigned fires[N];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic          mem_en    = 1'b0;
    logic          mem_force = 1'b0;
    logic          m_val     = 1'b0;
    logic          m_op      = 1'b0;
    logic [31:0]   m_data    = '0;
    logic [OB-1:0] m_opaq    = '0;

    assign bus.mem_resp_val  = m_val | mem_force;
    assign bus.mem_resp_op   = m_op;
    assign bus.mem_resp_data = m_data;
    assign bus.mem_resp_opaq = m_opaq;

    function automatic logic [31:0] mem_model(input logic op, input logic [31:0] addr);
        return op ? 32'h0 : (addr ^ 32'hDEAD_BEEF);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic trace();
        $display("[TRACE] t=%0t gnt=%0d count=%0d head=%0d", $time, dut.gnt, dut.count, dut.head);
    endtask

    // Drive point is posedge+1, the memory model updates at +2, checks happen at +4.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drain(input string tag);
        int unsigned k;
        k = 0;
        while ((sb.size() != 0 || memq.size() != 0) && k < 50) begin
            step();
            k++;
        end
        check_eq(tag, sb.size(), 0);
    endtask

    // In-order memory: presents the oldest accepted request one cycle after it fires.
    always @(posedge clk) begin
        #2;
        if (mem_en && rst && memq.size() > 0) begin
            m_val  = 1'b1;
            m_op   = memq[0].op;
            m_data = mem_model(memq[0].op, memq[0].addr);
            m_opaq = memq[0].opaq;
        end else begin
            m_val = 1'b0;
        end
    end

    // Monitor: inputs are stable mid-cycle, so val&rdy here is the fire at the next edge.
    always @(negedge clk) begin
        int unsigned nf;
        int unsigned nr;
        exp_t        e;
        mreq_t       m;
        nf = 0;
        nr = 0;
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.cli_req_val[i] && bus.cli_req_rdy[i]) begin
                    nf++;
                    fires[i]++;
                    grants.push_back(i);
                    check_eq("req_op",   bus.mem_req_op,   bus.cli_req_op[i]);
                    check_eq("req_addr", bus.mem_req_addr, bus.cli_req_addr[i]);
                    check_eq("req_data", bus.mem_req_data, bus.cli_req_data[i]);
                    check_eq("req_opaq", bus.mem_req_opaq, bus.cli_req_opaq[i]);
                    e.cli  = i;
                    e.op   = bus.cli_req_op[i];
                    e.data = mem_model(bus.cli_req_op[i], bus.cli_req_addr[i]);
                    e.opaq = bus.cli_req_opaq[i];
                    sb.push_back(e);
                end
            end
            check_eq("req_fire_count", nf, {31'b0, bus.mem_req_val & bus.mem_req_rdy});
            if (bus.mem_req_val && bus.mem_req_rdy) begin
                m.op   = bus.mem_req_op;
                m.addr = bus.mem_req_addr;
                m.data = bus.mem_req_data;
                m.opaq = bus.mem_req_opaq;
                memq.push_back(m);
            end
            if (bus.mem_resp_val && bus.mem_resp_rdy && memq.size() > 0) begin
                void'(memq.pop_front());
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.cli_resp_val[i] && bus.cli_resp_rdy[i]) begin
                    nr++;
                    check_eq("resp_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_eq("resp_client", i, e.cli);
                        check_eq("resp_op",   bus.cli_resp_op,   e.op);
                        check_eq("resp_data", bus.cli_resp_data, e.data);
                        check_eq("resp_opaq", bus.cli_resp_opaq, e.opaq);
                    end
                end
            end
            check_eq("resp_fire_count", nr, {31'b0, bus.mem_resp_val & bus.mem_resp_rdy});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cli_req_val  = '0;
        bus.cli_req_op   = '0;
        bus.cli_req_addr = '0;
        bus.cli_req_data = '0;
        bus.cli_req_opaq = '0;
        bus.cli_resp_rdy = '1;
        bus.mem_req_rdy  = 1'b1;
        foreach (fires[i]) fires[i] = 0;

        // Reset holds every handshake output low despite active inputs.
        bus.cli_req_val = '1;
        mem_force       = 1'b1;
        #12;
        check_eq("rst_cli_req_rdy",  bus.cli_req_rdy,  2'b00);
        check_eq("rst_mem_req_val",  bus.mem_req_val,  1'b0);
        check_eq("rst_cli_resp_val", bus.cli_resp_val, 2'b00);
        check_eq("rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        bus.cli_req_val = '0;
        mem_force       = 1'b0;
        step();
        rst = 1'b1;
        trace();

        // Round-robin with both clients always valid.
        mem_en = 1'b1;
        step();
        bus.cli_req_val     = 2'b11;
        bus.cli_req_addr[0] = 32'h40;
        bus.cli_req_addr[1] = 32'h80;
        bus.cli_req_opaq[0] = 8'h11;
        bus.cli_req_opaq[1] = 8'h22;
        bus.mem_req_rdy     = 1'b0;
        settle();
        check_eq("stall_mem_req_val", bus.mem_req_val, 1'b1);
        check_eq("stall_cli_req_rdy", bus.cli_req_rdy, 2'b00);
        check_eq("first_grant_opaq",  bus.mem_req_opaq, 8'h11);
        step();
        bus.mem_req_rdy = 1'b1;
        settle();
        check_eq("rr_rdy_first", bus.cli_req_rdy, 2'b01);
        grants.delete();
        repeat (6) step();
        bus.cli_req_val = '0;
        trace();
        check_eq("rr_grant_count", grants.size(), 6);
        for (int unsigned k = 0; k < grants.size(); k++) begin
            check_eq("rr_grant", grants[k], k % 2);
        end
        drain("drain_rr");

        // Fill the ID FIFO from client 1 with memory responses withheld.
        mem_en   = 1'b0;
        step();
        fires[1] = 0;
        bus.cli_req_val     = 2'b10;
        bus.cli_req_op[1]   = 1'b0;
        bus.cli_req_addr[1] = 32'h200;
        bus.cli_req_opaq[1] = 8'h40;
        repeat (4) step();
        settle();
        trace();
        check_eq("full_fires",       fires[1], 4);
        check_eq("full_cli_req_rdy", bus.cli_req_rdy, 2'b00);
        check_eq("full_mem_req_val", bus.mem_req_val, 1'b0);
        repeat (2) begin
            step();
            settle();
            check_eq("full_hold_rdy", bus.cli_req_rdy, 2'b00);
        end

        // At full, a response fires while the pending request waits one more cycle.
        step();
        mem_en = 1'b1;
        settle();
        check_eq("full_resp_rdy",  bus.mem_resp_rdy, 1'b1);
        check_eq("full_resp_val",  bus.cli_resp_val, 2'b10);
        check_eq("full_req_block", bus.cli_req_rdy,  2'b00);
        step();
        settle();
        check_eq("after_pop_rdy",   bus.cli_req_rdy, 2'b10);
        check_eq("after_pop_fires", fires[1], 4);
        step();
        bus.cli_req_val = '0;
        settle();
        check_eq("fifth_fired", fires[1], 5);
        drain("drain_full");

        // Head client 0 stalls its response for 3 cycles; client 1 still issues.
        step();
        bus.cli_req_val     = 2'b01;
        bus.cli_req_op[0]   = 1'b0;
        bus.cli_req_addr[0] = 32'h0;
        bus.cli_req_opaq[0] = 8'h34;
        bus.cli_resp_rdy    = 2'b10;
        step();
        bus.cli_req_val = '0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            if (k == 1) begin
                bus.cli_req_val     = 2'b10;
                bus.cli_req_addr[1] = 32'h300;
                bus.cli_req_opaq[1] = 8'h77;
            end
            if (k == 2) bus.cli_req_val = '0;
            settle();
            check_eq("hold_mem_resp_rdy", bus.mem_resp_rdy,  1'b0);
            check_eq("hold_cli_resp_val", bus.cli_resp_val,  2'b01);
            check_eq("hold_data",         bus.cli_resp_data, 32'hDEAD_BEEF);
            check_eq("hold_opaq",         bus.cli_resp_opaq, 8'h34);
            if (k == 1) check_eq("issue_while_stalled", bus.cli_req_rdy, 2'b10);
        end
        step();
        bus.cli_resp_rdy = '1;
        settle();
        check_eq("release_mem_resp_rdy", bus.mem_resp_rdy, 1'b1);
        check_eq("release_cli_resp_val", bus.cli_resp_val, 2'b01);
        drain("drain_hold");

        // Write from client 1.
        step();
        bus.cli_req_val     = 2'b10;
        bus.cli_req_op[1]   = 1'b1;
        bus.cli_req_addr[1] = 32'h100;
        bus.cli_req_data[1] = 32'h5;
        bus.cli_req_opaq[1] = 8'h36;
        settle();
        check_eq("wr_mem_req_val",  bus.mem_req_val,  1'b1);
        check_eq("wr_mem_req_op",   bus.mem_req_op,   1'b1);
        check_eq("wr_mem_req_addr", bus.mem_req_addr, 32'h100);
        check_eq("wr_mem_req_data", bus.mem_req_data, 32'h5);
        check_eq("wr_cli_req_rdy",  bus.cli_req_rdy,  2'b10);
        step();
        bus.cli_req_val = '0;
        settle();
        check_eq("wr_resp_val", bus.cli_resp_val, 2'b10);
        check_eq("wr_resp_op",  bus.cli_resp_op,  1'b1);
        drain("drain_wr");
        bus.cli_req_op[1] = 1'b0;

        // Asynchronous reset with two requests outstanding, last grant to client 0.
        mem_en = 1'b0;
        step();
        bus.cli_req_val     = 2'b10;
        bus.cli_req_addr[1] = 32'h400;
        bus.cli_req_opaq[1] = 8'h51;
        step();
        bus.cli_req_val     = 2'b01;
        bus.cli_req_addr[0] = 32'h500;
        bus.cli_req_opaq[0] = 8'h52;
        step();
        bus.cli_req_val = '0;
        settle();
        trace();
        bus.cli_req_val = 2'b11;
        mem_force       = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check_eq("arst_cli_req_rdy",  bus.cli_req_rdy,  2'b00);
        check_eq("arst_mem_req_val",  bus.mem_req_val,  1'b0);
        check_eq("arst_cli_resp_val", bus.cli_resp_val, 2'b00);
        check_eq("arst_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        sb.delete();
        memq.delete();
        step();
        step();
        rst = 1'b1;
        settle();
        check_eq("post_rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        check_eq("post_rst_cli_resp_val", bus.cli_resp_val, 2'b00);
        check_eq("post_rst_cli_req_rdy",  bus.cli_req_rdy,  2'b01);
        mem_force = 1'b0;
        mem_en    = 1'b1;
        grants.delete();
        step();
        bus.cli_req_val = '0;
        check_eq("post_rst_grants", grants.size(), 1);
        if (grants.size() > 0) check_eq("post_rst_grant", grants[0], 0);
        drain("drain_rst");
        trace();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter p_num_clients, default 2, number of requesting memory clients (client 0 = fetch, client 1 = load/store).
REQ-002 SHALL have parameter p_opaq_bits, default 8, opaque tag width carried unchanged from request to response.
REQ-003 SHALL have parameter p_max_inflight, default 4, power of two, maximum outstanding memory requests.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset: rst=0 resets immediately regardless of clk.
REQ-006 cli_req_val  in  p_num_clients  per-client request valid.
REQ-007 cli_req_rdy  out  p_num_clients  per-client request ready.
REQ-008 cli_req_op / cli_req_addr / cli_req_data / cli_req_opaq  in  N x 1 / N x 32 / N x 32 / N x p_opaq_bits  op (0 read, 1 write), address, write data, tag.
REQ-009 cli_resp_val  out  p_num_clients  per-client response valid.
REQ-010 cli_resp_rdy  in  p_num_clients  per-client response ready.
REQ-011 cli_resp_op / cli_resp_data / cli_resp_opaq  out  1 / 32 / p_opaq_bits  shared response fields, broadcast to all clients.
REQ-012 mem_req_val  out 1; mem_req_rdy  in 1; mem_req_op / addr / data / opaq  out  1 / 32 / 32 / p_opaq_bits  downstream request.
REQ-013 mem_resp_val  in 1; mem_resp_rdy  out 1; mem_resp_op / data / opaq  in  1 / 32 / p_opaq_bits  downstream response; memory returns responses in request order.

Function
REQ-014 Fire = val & rdy on the same edge; a request or response SHALL transfer exactly once per fire.
REQ-015 Grant SHALL be round-robin: priority pointer ptr (clog2 N bits); the first valid client at or after ptr, wrapping modulo N, is granted.
REQ-016 Request path SHALL be combinational (zero latency): mem_req_val = any cli_req_val & ~full; mem_req fields = granted client's fields.
REQ-017 cli_req_rdy[i] SHALL be 1 only for the granted client i, and only when mem_req_rdy=1 and ~full; all others 0.
REQ-018 On request fire to client g, ptr SHALL become (g+1) mod N next cycle; ptr SHALL be unchanged on cycles with no fire.
REQ-019 A client-ID FIFO, depth p_max_inflight, SHALL push granted ID on request fire and pop on mem_resp fire.
REQ-020 full = (count == p_max_inflight); push with full SHALL never occur; simultaneous push and pop at full SHALL NOT be allowed (no bypass, request stalls).
REQ-021 Simultaneous push and pop when not full and not empty SHALL leave count unchanged; read/write pointers wrap modulo p_max_inflight.
REQ-022 Response path SHALL be combinational: cli_resp_val[h] = mem_resp_val & ~empty for h = FIFO head ID, other bits 0; mem_resp_rdy = cli_resp_rdy[h] & ~empty.
REQ-023 cli_resp fields SHALL equal mem_resp fields unmodified; opaq SHALL be returned as issued.
REQ-024 mem_resp_val while empty is a protocol error: mem_resp_rdy SHALL stay 0 and no client sees valid.
REQ-025 A stalled client response (cli_resp_rdy[h]=0) SHALL back-pressure memory and SHALL NOT block new request issue while not full.
REQ-026 Clients with no valid request SHALL not affect ptr or grant of others.
REQ-027 Provide trace() (non-synthesis) printing granted client, count, head ID.

Reset
REQ-028 On rst=0: ptr=0, FIFO count=0, read/write pointers=0; all cli_req_rdy, cli_resp_val, mem_req_val, mem_resp_rdy SHALL read 0 while rst=0.
REQ-029 Reset mid-operation SHALL discard all in-flight IDs; responses for pre-reset requests are not routed.
REQ-030 First grant after reset release SHALL favour client 0.

Verification
REQ-031 Both clients valid continuously, mem always ready, responses delayed 1 cycle -> grants alternate 0,1,0,1; each response reaches issuer with its opaq (e.g. 0x11 -> client 0, 0x22 -> client 1).
REQ-032 Client 1 only, 4 reads, mem_resp withheld -> 4 fires, count=4, 5th request stalled (cli_req_rdy[1]=0) until one response fires.
REQ-033 Full FIFO, mem_resp_val=1 and new request same cycle -> response fires, request does not; request fires next cycle.
REQ-034 Head client 0 holds cli_resp_rdy=0 for 3 cycles -> mem_resp_rdy=0 those cycles, data 0xDEADBEEF held, delivered on cycle 4.
REQ-035 Assert rst=0 asynchronously with 2 outstanding -> outputs zero before next edge; after release count=0, client 0 wins simultaneous request.
REQ-036 Write op=1 addr 0x100 data 0x5 from client 1 -> mem_req fields match exactly; response op=1 routed to client 1.
